// File: rtl/reg_f_mp_if.sv
// Bus bundle between decode/writeback (master) and the multi-port register file (slave).
// Read port k occupies slice [k*AddrSize +: AddrSize] of read_address and [k*DataSize +: DataSize] of read_data.
interface reg_f_mp_if #(
  parameter int DataSize = 32,
  parameter int AddrSize = 5,
  parameter int Depth    = 2**AddrSize,
  parameter int NumRd    = 3
);

  logic                      read;
  logic [NumRd*AddrSize-1:0] read_address;
  logic [NumRd*DataSize-1:0] read_data;
  logic [NumRd-1:0]          read_busy;

  logic                      write0;
  logic [AddrSize-1:0]       write_address0;
  logic [DataSize-1:0]       write_data0;
  logic                      write1;
  logic [AddrSize-1:0]       write_address1;
  logic [DataSize-1:0]       write_data1;

  logic                      reserve;
  logic [AddrSize-1:0]       reserve_address;
  logic [Depth-1:0]          busy;

  modport master (
    output read, read_address,
    output write0, write_address0, write_data0,
    output write1, write_address1, write_data1,
    output reserve, reserve_address,
    input  read_data, read_busy, busy
  );

  modport slave (
    input  read, read_address,
    input  write0, write_address0, write_data0,
    input  write1, write_address1, write_data1,
    input  reserve, reserve_address,
    output read_data, read_busy, busy
  );

endinterface

// File: rtl/reg_f_mp.sv
// Multi-port register file: NumRd registered read ports, two write ports with write-first bypass
// (port 1 has priority), optional hardwired-zero r0 and a per-register busy scoreboard.
module reg_f_mp #(
  parameter int DataSize = 32,
  parameter int AddrSize = 5,
  parameter int Depth    = 2**AddrSize,
  parameter int NumRd    = 3,
  parameter bit R0Zero   = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  reg_f_mp_if.slave bus
);

  logic [DataSize-1:0]       regs_r [Depth];
  logic [Depth-1:0]          busy_r;
  logic [Depth-1:0]          busy_nxt_s;
  logic [Depth-1:0]          we0_s;
  logic [Depth-1:0]          we1_s;
  logic [Depth-1:0]          rsv_s;
  logic [NumRd*DataSize-1:0] rd_data_r;
  logic [NumRd*DataSize-1:0] rd_data_nxt_s;
  logic [NumRd-1:0]          rd_busy_r;
  logic [NumRd-1:0]          rd_busy_nxt_s;
  logic                      hit_s;
  logic [DataSize-1:0]       val_s;

  // Register idx is addressed by an enabled access; out-of-range addresses never match and r0 drops out when hardwired.
  function automatic logic addr_hit(input logic en, input logic [AddrSize-1:0] addr, input int idx);
    return en && (addr == AddrSize'(idx)) && !(R0Zero && (idx == 0));
  endfunction

  // Decode per-register write and reserve strobes
  always_comb begin
    we0_s = '0;
    we1_s = '0;
    rsv_s = '0;
    for (int i = 0; i < Depth; i++) begin
      we0_s[i] = addr_hit(bus.write0,  bus.write_address0,  i);
      we1_s[i] = addr_hit(bus.write1,  bus.write_address1,  i);
      rsv_s[i] = addr_hit(bus.reserve, bus.reserve_address, i);
    end
  end

  // Scoreboard next state: a completing write clears, a new reservation sets and wins
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < Depth; i++) begin
      busy_nxt_s[i] = rsv_s[i] | (busy_r[i] & ~(we0_s[i] | we1_s[i]));
    end
  end

  // Read muxes with write-first bypass; at most one register matches per port so results are OR-combined
  always_comb begin
    rd_data_nxt_s = '0;
    rd_busy_nxt_s = '0;
    hit_s         = 1'b0;
    val_s         = '0;
    for (int k = 0; k < NumRd; k++) begin
      for (int i = 0; i < Depth; i++) begin
        hit_s = addr_hit(bus.read, bus.read_address[k*AddrSize +: AddrSize], i);
        val_s = we1_s[i] ? bus.write_data1 : (we0_s[i] ? bus.write_data0 : regs_r[i]);
        rd_data_nxt_s[k*DataSize +: DataSize] = rd_data_nxt_s[k*DataSize +: DataSize]
                                              | ({DataSize{hit_s}} & val_s);
        rd_busy_nxt_s[k] = rd_busy_nxt_s[k] | (hit_s & busy_nxt_s[i]);
      end
    end
  end

  // Register storage; port 1 overrides port 0 on a shared address
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (we1_s[i]) begin
          regs_r[i] <= bus.write_data1;
        end else if (we0_s[i]) begin
          regs_r[i] <= bus.write_data0;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Scoreboard and read-port output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r    <= '0;
      rd_data_r <= '0;
      rd_busy_r <= '0;
    end else begin
      busy_r    <= busy_nxt_s;
      rd_data_r <= rd_data_nxt_s;
      rd_busy_r <= rd_busy_nxt_s;
    end
  end

  assign bus.read_data = rd_data_r;
  assign bus.read_busy = rd_busy_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_reg_f_mp.sv
// Directed bench for reg_f_mp: one default instance (Depth 32, hardwired r0) and one with
// Depth 20 and a writable r0, checked against hand-computed values.
module tb_reg_f_mp;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  reg_f_mp_if #(.DataSize(32), .AddrSize(5), .Depth(32), .NumRd(3)) ia ();
  reg_f_mp_if #(.DataSize(32), .AddrSize(5), .Depth(20), .NumRd(3)) ib ();

  reg_f_mp #(.DataSize(32), .AddrSize(5), .Depth(32), .NumRd(3), .R0Zero(1'b1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia.slave)
  );

  reg_f_mp #(.DataSize(32), .AddrSize(5), .Depth(20), .NumRd(3), .R0Zero(1'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ia.read = 1'b0; ia.read_address = '0;
    ia.write0 = 1'b0; ia.write_address0 = '0; ia.write_data0 = '0;
    ia.write1 = 1'b0; ia.write_address1 = '0; ia.write_data1 = '0;
    ia.reserve = 1'b0; ia.reserve_address = '0;
    ib.read = 1'b0; ib.read_address = '0;
    ib.write0 = 1'b0; ib.write_address0 = '0; ib.write_data0 = '0;
    ib.write1 = 1'b0; ib.write_address1 = '0; ib.write_data1 = '0;
    ib.reserve = 1'b0; ib.reserve_address = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk         = 1'b0;
    reset       = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy_a", ia.busy, 32'h0);
    chk("rst_rdata_a", ia.read_data, 96'h0);
    chk("rst_rbusy_a", ia.read_busy, 3'b000);

    // populate a few registers and a reservation, then reset over a pending write
    ia.write0 = 1'b1; ia.write_address0 = 5'd1; ia.write_data0 = 32'h1111_1111;
    ia.write1 = 1'b1; ia.write_address1 = 5'd2; ia.write_data1 = 32'h2222_2222;
    ia.reserve = 1'b1; ia.reserve_address = 5'd4;
    tick();
    chk("pre_busy_a", ia.busy, 32'h0000_0010);
    idle();
    reset = 1'b1;
    ia.write0 = 1'b1; ia.write_address0 = 5'd3; ia.write_data0 = 32'h3333_3333;
    ia.read = 1'b1; ia.read_address = {5'd3, 5'd2, 5'd1};
    tick();
    reset = 1'b0;
    idle();
    chk("rst_ovr_rdata", ia.read_data, 96'h0);
    chk("rst_ovr_busy", ia.busy, 32'h0);
    for (int a = 0; a < 32; a++) begin
      ia.read = 1'b1;
      ia.read_address = {5'(a + 2), 5'(a + 1), 5'(a)};
      tick();
      chk($sformatf("rst_rd_%0d", a), {ia.read_busy, ia.read_data}, 99'h0);
    end

    // write-first bypass on port 0
    idle();
    ia.write0 = 1'b1; ia.write_address0 = 5'd5; ia.write_data0 = 32'hDEAD_BEEF;
    ia.read = 1'b1; ia.read_address = {5'd0, 5'd0, 5'd5};
    tick();
    chk("bypass_r5", ia.read_data, {32'h0, 32'h0, 32'hDEAD_BEEF});

    // write collision: port 1 wins, both in bypass and in storage
    idle();
    ia.write0 = 1'b1; ia.write_address0 = 5'd7; ia.write_data0 = 32'h0000_0011;
    ia.write1 = 1'b1; ia.write_address1 = 5'd7; ia.write_data1 = 32'h0000_0022;
    ia.read = 1'b1; ia.read_address = {5'd0, 5'd7, 5'd0};
    tick();
    chk("coll_bypass", ia.read_data, {32'h0, 32'h0000_0022, 32'h0});
    idle();
    ia.read = 1'b1; ia.read_address = {5'd7, 5'd5, 5'd0};
    tick();
    chk("coll_stored", ia.read_data, {32'h0000_0022, 32'hDEAD_BEEF, 32'h0});

    // hardwired r0: writes and reservations ignored
    idle();
    ia.write0 = 1'b1; ia.write_address0 = 5'd0; ia.write_data0 = 32'hFFFF_FFFF;
    ia.reserve = 1'b1; ia.reserve_address = 5'd0;
    ia.read = 1'b1; ia.read_address = {5'd0, 5'd0, 5'd0};
    tick();
    chk("r0z_bypass", {ia.read_busy, ia.read_data}, 99'h0);
    chk("r0z_busy", ia.busy, 32'h0);
    idle();
    ia.read = 1'b1; ia.read_address = {5'd0, 5'd0, 5'd0};
    tick();
    chk("r0z_stored", {ia.read_busy, ia.read_data}, 99'h0);

    // writable r0 on the second instance
    idle();
    ib.write0 = 1'b1; ib.write_address0 = 5'd0; ib.write_data0 = 32'hFFFF_FFFF;
    ib.reserve = 1'b1; ib.reserve_address = 5'd0;
    ib.read = 1'b1; ib.read_address = {5'd0, 5'd0, 5'd0};
    tick();
    chk("r0w_rdata", ib.read_data, {3{32'hFFFF_FFFF}});
    chk("r0w_rbusy", ib.read_busy, 3'b111);
    chk("r0w_busy", ib.busy, 20'h0_0001);

    // scoreboard: reserve, reserve beats write, lone write clears
    idle();
    ia.reserve = 1'b1; ia.reserve_address = 5'd3;
    ia.read = 1'b1; ia.read_address = {5'd0, 5'd0, 5'd3};
    tick();
    chk("sb_rsv_busy", ia.busy, 32'h0000_0008);
    chk("sb_rsv_rbusy", ia.read_busy, 3'b001);
    idle();
    ia.write1 = 1'b1; ia.write_address1 = 5'd3; ia.write_data1 = 32'h0000_00AB;
    ia.reserve = 1'b1; ia.reserve_address = 5'd3;
    ia.read = 1'b1; ia.read_address = {5'd0, 5'd0, 5'd3};
    tick();
    chk("sb_setwin_busy", ia.busy, 32'h0000_0008);
    chk("sb_setwin_rd", {ia.read_busy, ia.read_data}, {3'b001, 32'h0, 32'h0, 32'h0000_00AB});
    idle();
    ia.write0 = 1'b1; ia.write_address0 = 5'd3; ia.write_data0 = 32'h0000_00CD;
    ia.read = 1'b1; ia.read_address = {5'd0, 5'd0, 5'd3};
    tick();
    chk("sb_clr_busy", ia.busy, 32'h0);
    chk("sb_clr_rd", {ia.read_busy, ia.read_data}, {3'b000, 32'h0, 32'h0, 32'h0000_00CD});
    idle();
    ia.reserve = 1'b1; ia.reserve_address = 5'd10;
    ia.write1 = 1'b1; ia.write_address1 = 5'd11; ia.write_data1 = 32'h0000_003C;
    tick();
    chk("sb_nonbusy_wr", ia.busy, 32'h0000_0400);
    idle();
    ia.reserve = 1'b1; ia.reserve_address = 5'd12;
    tick();
    chk("sb_rsv12", ia.busy, 32'h0000_1400);
    idle();
    ia.write0 = 1'b1; ia.write_address0 = 5'd12; ia.write_data0 = 32'h0000_0012;
    ia.write1 = 1'b1; ia.write_address1 = 5'd10; ia.write_data1 = 32'h0000_0010;
    ia.read = 1'b1; ia.read_address = {5'd9, 5'd3, 5'd3};
    tick();
    chk("sb_dual_clr", ia.busy, 32'h0);
    chk("pre_idle_rd", ia.read_data, {32'h0, 32'h0000_00CD, 32'h0000_00CD});

    // read disabled zeroes the outputs while the write still lands
    idle();
    ia.write0 = 1'b1; ia.write_address0 = 5'd9; ia.write_data0 = 32'h0000_0055;
    ia.read_address = {5'd9, 5'd9, 5'd9};
    tick();
    chk("rd_off", {ia.read_busy, ia.read_data}, 99'h0);
    idle();
    ia.read = 1'b1; ia.read_address = {5'd9, 5'd12, 5'd10};
    tick();
    chk("rd_after_off", ia.read_data, {32'h0000_0055, 32'h0000_0012, 32'h0000_0010});

    // Depth 20: last register works, out-of-range write/reserve ignored
    idle();
    ib.write1 = 1'b1; ib.write_address1 = 5'd19; ib.write_data1 = 32'h0000_0099;
    ib.write0 = 1'b1; ib.write_address0 = 5'd25; ib.write_data0 = 32'h0000_0077;
    ib.reserve = 1'b1; ib.reserve_address = 5'd25;
    ib.read = 1'b1; ib.read_address = {5'd25, 5'd19, 5'd0};
    tick();
    chk("oor_rd", ib.read_data, {32'h0, 32'h0000_0099, 32'hFFFF_FFFF});
    chk("oor_busy", ib.busy, 20'h0_0001);
    idle();
    ib.read = 1'b1; ib.read_address = {5'd25, 5'd19, 5'd25};
    tick();
    chk("oor_stored", {ib.read_busy, ib.read_data}, {3'b000, 32'h0, 32'h0000_0099, 32'h0});

    // mid-stream reset discards stored data and reservations
    idle();
    ib.reserve = 1'b1; ib.reserve_address = 5'd6;
    ib.write0 = 1'b1; ib.write_address0 = 5'd6; ib.write_data0 = 32'h0000_0066;
    tick();
    chk("mid_pre_busy", ib.busy, 20'h0_0041);
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ib.read = 1'b1; ib.read_address = {5'd19, 5'd0, 5'd6};
    tick();
    chk("mid_rst_rd", {ib.read_busy, ib.read_data}, 99'h0);
    chk("mid_rst_busy", ib.busy, 20'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
